// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and default sizes for the IF/MEM bus arbiter.
package mem_bus_arbiter_pkg;

    // Native register width of the core; both bus widths follow it.
    localparam int RegBus      = 32;
    localparam int ARB_ADDR_W  = RegBus;
    localparam int ARB_DATA_W  = RegBus;
    localparam int ARB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ArbIdle    = 2'd0,
        ArbIfWait  = 2'd1,
        ArbMemWait = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// Bus wait counter: cleared on each grant, bumped on each wait edge,
// expire flags the last allowed wait edge. TIMEOUT=0 never expires.
module bus_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins over increment; frozen when disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (TIMEOUT != 0)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between the fetch port and the data port.
// One transaction at a time; MEM has fixed priority over IF.
//
// Handshake: a port raises req and holds it (with stable address/data)
// until its ack pulses for exactly one cycle; rdata is valid in that cycle.
// A req seen while its own ack is high is not a new request. On the bus
// side, bus_stb and the bus_* qualifiers stay stable until a bus_ack edge;
// bus_ack is ignored whenever bus_stb is low.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int DATA_W  = ARB_DATA_W,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [DATA_W/8-1:0] mem_sel,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_ack,
    input  logic                flush,
    output logic                stallreq_if,
    output logic                stallreq_mem,
    output logic                bus_err,
    output logic                bus_stb,
    output logic                bus_we,
    output logic [DATA_W/8-1:0] bus_sel,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ack,
    output arb_state_e          dbg_state
);

    arb_state_e          state_q, state_d;
    logic                flushed_q, flushed_d;
    logic                bus_stb_q, bus_stb_d;
    logic                bus_we_q, bus_we_d;
    logic [DATA_W/8-1:0] bus_sel_q, bus_sel_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic                if_ack_q, if_ack_d;
    logic                mem_ack_q, mem_ack_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                bus_err_q, bus_err_d;

    logic                wd_clr, wd_inc, wd_expire;
    logic                if_elig, mem_elig, if_drop;

    bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .inc    (wd_inc),
        .expire (wd_expire)
    );

    // A port still holding req during its own ack cycle is not re-granted.
    assign if_elig  = if_req  & ~if_ack_q;
    assign mem_elig = mem_req & ~mem_ack_q;
    // A flush in the completing cycle counts as well as an earlier one.
    assign if_drop  = flushed_q | flush;

    // Arbitration, bus sequencing and completion reporting.
    always_comb begin
        state_d     = state_q;
        flushed_d   = flushed_q;
        bus_stb_d   = bus_stb_q;
        bus_we_d    = bus_we_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        bus_err_d   = 1'b0;
        wd_clr      = 1'b0;
        wd_inc      = 1'b0;
        unique case (state_q)
            ArbIdle: begin
                flushed_d = 1'b0;
                if (mem_elig) begin
                    state_d     = ArbMemWait;
                    bus_stb_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_sel_d   = mem_sel;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    wd_clr      = 1'b1;
                end else if (if_elig) begin
                    state_d    = ArbIfWait;
                    bus_stb_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_sel_d  = '1;
                    bus_addr_d = if_addr;
                    wd_clr     = 1'b1;
                end
            end
            ArbIfWait: begin
                if (flush) begin
                    flushed_d = 1'b1;
                end
                if (bus_ack) begin
                    state_d   = ArbIdle;
                    bus_stb_d = 1'b0;
                    flushed_d = 1'b0;
                    if (!if_drop) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus_rdata;
                    end
                end else if (wd_expire) begin
                    state_d   = ArbIdle;
                    bus_stb_d = 1'b0;
                    flushed_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (!if_drop) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = '0;
                    end
                end else begin
                    wd_inc = 1'b1;
                end
            end
            ArbMemWait: begin
                if (bus_ack) begin
                    state_d   = ArbIdle;
                    bus_stb_d = 1'b0;
                    mem_ack_d = 1'b1;
                    if (!bus_we_q) begin
                        mem_rdata_d = bus_rdata;
                    end
                end else if (wd_expire) begin
                    state_d     = ArbIdle;
                    bus_stb_d   = 1'b0;
                    mem_ack_d   = 1'b1;
                    bus_err_d   = 1'b1;
                    mem_rdata_d = '0;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            default: begin
                state_d   = ArbIdle;
                bus_stb_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ArbIdle;
            flushed_q   <= 1'b0;
            bus_stb_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            flushed_q   <= flushed_d;
            bus_stb_q   <= bus_stb_d;
            bus_we_q    <= bus_we_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign if_rdata     = if_rdata_q;
    assign if_ack       = if_ack_q;
    assign mem_rdata    = mem_rdata_q;
    assign mem_ack      = mem_ack_q;
    assign bus_err      = bus_err_q;
    assign bus_stb      = bus_stb_q;
    assign bus_we       = bus_we_q;
    assign bus_sel      = bus_sel_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign stallreq_if  = if_req & ~if_ack_q;
    assign stallreq_mem = mem_req & ~mem_ack_q;
    assign dbg_state    = state_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external memory bus between the instruction-fetch port (IF, driven by the PC) and the data port (MEM stage, loads and stores).
- Runs one bus transaction at a time through a registered state machine.
- Returns read data and a one-cycle completion pulse to the requester.
- Raises per-port stall requests so the pipeline controller can freeze the earlier stages.
- A watchdog aborts bus transactions that never complete.

Parameters:
- ADDR_W, 32, address width of both ports and the bus.
- DATA_W, 32, data width.
- TIMEOUT, 16, maximum bus wait in cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous active-low reset: sampled low at a rising clk edge resets all state.
- if_req  in  1  instruction fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; valid in the if_ack cycle.
- if_ack  out  1  one-cycle completion pulse for the fetch port.
- mem_req  in  1  data access request; held until mem_ack.
- mem_we  in  1  1 = write, 0 = read.
- mem_sel  in  DATA_W/8  byte enables.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  write data.
- mem_rdata  out  DATA_W  read data; valid in the mem_ack cycle.
- mem_ack  out  1  one-cycle completion pulse for the data port.
- flush  in  1  pipeline flush; discards the result of an in-flight fetch.
- stallreq_if  out  1  = if_req & ~if_ack (combinational).
- stallreq_mem  out  1  = mem_req & ~mem_ack (combinational).
- bus_err  out  1  one-cycle pulse on a watchdog abort.
- bus_stb  out  1  bus strobe, registered.
- bus_we  out  1  bus write enable, registered.
- bus_sel  out  DATA_W/8  bus byte enables, registered.
- bus_addr  out  ADDR_W  bus address, registered.
- bus_wdata  out  DATA_W  bus write data, registered.
- bus_rdata  in  DATA_W  bus read data, sampled when bus_ack=1.
- bus_ack  in  1  slave completion; only meaningful while bus_stb=1.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE, watchdog count=0, flushed flag=0.
  - All registered outputs become 0: bus_stb, bus_we, bus_sel, bus_addr, bus_wdata, if_ack, mem_ack, if_rdata, mem_rdata, bus_err.
  - Reset in the middle of a transaction drops it. Any late bus_ack is ignored because bus_stb=0.
- States: IDLE, IF_WAIT, MEM_WAIT.
- IDLE, arbitration:
  - Fixed priority: MEM beats IF, because the MEM instruction is older.
  - A port is eligible only when its req=1 and its ack output is 0 in this cycle. This prevents re-issuing a request that is still held during its own ack cycle.
  - MEM granted: go to MEM_WAIT. Register bus_stb=1 and load bus_addr, bus_we, bus_sel, bus_wdata from the mem_* inputs.
  - IF granted: go to IF_WAIT. Register bus_stb=1, bus_addr=if_addr, bus_we=0, bus_sel=all ones.
  - Watchdog cleared on every grant.
- *_WAIT:
  - Bus outputs are held stable until completion.
  - On an edge with bus_ack=1:
    - bus_stb<=0 and the state returns to IDLE.
    - The matching *_rdata<=bus_rdata and the matching *_ack<=1 for exactly one cycle.
    - For writes, mem_rdata is unchanged.
  - On an edge with bus_ack=0 and TIMEOUT≠0: the watchdog increments. When it reaches TIMEOUT-1:
    - bus_stb<=0 and the state returns to IDLE.
    - bus_err<=1 and the matching *_ack<=1, both for one cycle.
    - rdata<=0.
- Latency: a request is seen in IDLE at edge k and bus_stb is high after edge k. If the slave acks in the first strobe cycle, the requester's ack is high after edge k+1. Minimum request-to-ack is 2 cycles.
- Back-to-back requests: the next grant can happen in the ack cycle of the previous transaction, but only for the other port. The same port waits one more cycle.
- Flush:
  - flush=1 during IF_WAIT sets the flushed flag. The bus transaction still completes, because bus cycles cannot be aborted.
  - On completion if_ack stays 0 and if_rdata is not updated. The flag clears on return to IDLE.
  - flush has no effect on MEM_WAIT, since stores must complete, and no effect in IDLE.
- Simultaneous if_req and mem_req in IDLE: MEM is served first and IF waits; stallreq_if stays 1 throughout.
- A req dropped mid-transaction is ignored and the transaction completes normally.

Decomposition:
- The shared package (defines file) holds:
  - The state encodings `ArbIdle`, `ArbIfWait`, `ArbMemWait` (2 bits).
  - ADDR_W and DATA_W, aligned with `RegBus`.
  - The default TIMEOUT.
- One sub-module, bus_watchdog:
  - A counter with clr and inc inputs and an expire output.
  - Parameterised by TIMEOUT, with the counter width taken from clog2(TIMEOUT).

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, slave acks 1 cycle after stb with 0x3C010101 -> bus_addr=0x100 and bus_we=0; if_ack pulses once, 2 cycles after the request, with if_rdata=0x3C010101.
- Contention: if_req and mem_req rise together; mem_we=1, mem_addr=0x200, mem_wdata=0xDEADBEEF, mem_sel=4'b1111 -> write goes first; mem_ack pulse; fetch starts the next cycle; stallreq_if stays 1 until if_ack.
- Held request: if_req kept high across if_ack, slave with 0 wait -> exactly one bus transaction per ack and no duplicate strobe in the ack cycle.
- Flush: flush=1 during IF_WAIT, slave acks 3 cycles later with 0x12345678 -> no if_ack; if_rdata unchanged; state IDLE afterwards.
- Timeout: TIMEOUT=4, mem read, slave never acks -> bus_stb drops after 4 wait edges; bus_err and mem_ack pulse together; mem_rdata=0.
- Reset mid-transaction: rst=0 during MEM_WAIT -> all outputs 0 at the next edge; a later bus_ack produces no ack.
